// File: rtl/alu_pkg.sv
// Shared ALU op-code enum, FSM states and op-class helpers for the execute stage.
// The ALU controller imports the same alu_op_e so both ends agree on encoding.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_OR   = 4'h1,
    OP_XOR  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_SRL  = 4'h5,
    OP_SRA  = 4'h6,
    OP_SLL  = 4'h7,
    OP_SLA  = 4'h8,
    OP_EQ   = 4'h9,
    OP_NE   = 4'hA,
    OP_SLT  = 4'hB,
    OP_GE   = 4'hC,
    OP_LUI  = 4'hD,
    OP_ILL0 = 4'hE,
    OP_ILL1 = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(alu_op_e op);
    return op inside {OP_SRL, OP_SRA, OP_SLL, OP_SLA};
  endfunction

  function automatic logic is_cmp_op(alu_op_e op);
    return op inside {OP_EQ, OP_NE, OP_SLT, OP_GE};
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Purely combinational single-cycle ALU ops; shift codes pass operand A through
// so a zero-amount shift completes in one cycle like any other op.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result_c,
  output logic             o_cond_c,
  output logic             o_illegal_c
);

  alu_op_e w_op;
  assign w_op = alu_op_e'(i_op);

  always_comb begin
    o_result_c  = '0;
    o_cond_c    = 1'b0;
    o_illegal_c = 1'b0;
    case (w_op)
      OP_AND:  o_result_c = i_a & i_b;
      OP_OR:   o_result_c = i_a | i_b;
      OP_XOR:  o_result_c = i_a ^ i_b;
      OP_ADD:  o_result_c = i_a + i_b;
      OP_SUB:  o_result_c = i_a - i_b;
      OP_SRL, OP_SRA, OP_SLL, OP_SLA: o_result_c = i_a;
      OP_EQ:   o_cond_c = (i_a == i_b);
      OP_NE:   o_cond_c = (i_a != i_b);
      OP_SLT:  o_cond_c = ($signed(i_a) <  $signed(i_b));
      OP_GE:   o_cond_c = ($signed(i_a) >= $signed(i_b));
      OP_LUI:  o_result_c = i_b;
      default: o_illegal_c = 1'b1;
    endcase
    // Compare results are the condition bit zero-extended.
    if (is_cmp_op(w_op)) o_result_c = WIDTH'(o_cond_c);
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle ops via alu_comb_core, iterative 1-bit/cycle
// shifts, valid/ready on both sides so the pipeline can stall on long shifts.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken,
  output logic             illegal_op
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  state_e             r_state, w_state_nxt;
  alu_op_e            r_op, w_op_nxt;
  logic [WIDTH-1:0]   r_work, w_work_nxt;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_result, w_result_nxt;
  logic               r_branch, w_branch_nxt;
  logic               r_illegal, w_illegal_nxt;
  logic               r_in_ready, w_in_ready_nxt;
  logic               r_out_valid, w_out_valid_nxt;

  alu_op_e            w_op;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_accept;
  logic               w_shift_start;
  logic [WIDTH-1:0]   w_step;
  logic [WIDTH-1:0]   w_core_result;
  logic               w_core_cond;
  logic               w_core_illegal;

  assign w_op          = alu_op_e'(operation);
  assign w_shamt       = src_b[SHAMT_W-1:0];
  assign w_accept      = in_valid && r_in_ready && !flush;
  assign w_shift_start = w_accept && is_shift_op(w_op) && (w_shamt != '0);

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .i_op        (operation),
    .i_a         (src_a),
    .i_b         (src_b),
    .o_result_c  (w_core_result),
    .o_cond_c    (w_core_cond),
    .o_illegal_c (w_core_illegal)
  );

  // One-bit shift step on the working register.
  always_comb begin
    w_step = r_work;
    case (r_op)
      OP_SRL:  w_step = {1'b0, r_work[WIDTH-1:1]};
      OP_SRA:  w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      OP_SLL:  w_step = {r_work[WIDTH-2:0], 1'b0};
      OP_SLA:  w_step = {r_work[WIDTH-1], r_work[WIDTH-3:0], 1'b0};
      default: w_step = r_work;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Flush overrides every transition, including accept and the out handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_shift_start ? S_SHIFT : S_DONE;
      S_SHIFT: if (r_cnt == SHAMT_W'(1)) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_op_nxt        = r_op;
    w_work_nxt      = r_work;
    w_cnt_nxt       = r_cnt;
    w_result_nxt    = r_result;
    w_branch_nxt    = r_branch;
    w_illegal_nxt   = r_illegal;
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
    if (flush) begin
      w_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_op_nxt = w_op;
            if (w_shift_start) begin
              w_work_nxt = src_a;
              w_cnt_nxt  = w_shamt;
            end else begin
              w_result_nxt  = w_core_result;
              w_branch_nxt  = w_core_cond;
              w_illegal_nxt = w_core_illegal;
            end
          end
        end
        S_SHIFT: begin
          w_work_nxt = w_step;
          w_cnt_nxt  = r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            w_result_nxt  = w_step;
            w_branch_nxt  = 1'b0;
            w_illegal_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= OP_AND;
      r_work      <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_branch    <= 1'b0;
      r_illegal   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_op        <= w_op_nxt;
      r_work      <= w_work_nxt;
      r_cnt       <= w_cnt_nxt;
      r_result    <= w_result_nxt;
      r_branch    <= w_branch_nxt;
      r_illegal   <= w_illegal_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign result       = r_result;
  assign branch_taken = r_branch;
  assign illegal_op   = r_illegal;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: expected results come from a reference model,
// are queued at issue and popped when the unit presents its output.
module tb_alu_seq_exec;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   operation;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         branch_taken;
  logic         illegal_op;

  int    checks = 0;
  int    errors = 0;
  string cur    = "reset";

  typedef struct {
    logic [31:0] res;
    logic        br;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq_exec #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .operation    (operation),
    .src_a        (src_a),
    .src_b        (src_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .illegal_op   (illegal_op)
  );

  function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int   sh;
    sh    = int'(b[4:0]);
    e.res = '0;
    e.br  = 1'b0;
    e.ill = 1'b0;
    e.lat = 1;
    case (op)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: e.res = a ^ b;
      4'h3: e.res = a + b;
      4'h4: e.res = a - b;
      4'h5: begin e.res = a >> sh; e.lat = sh + 1; end
      4'h6: begin e.res = 32'($signed(a) >>> sh); e.lat = sh + 1; end
      4'h7: begin e.res = a << sh; e.lat = sh + 1; end
      4'h8: begin e.res = {a[31], 31'(a[30:0] << sh)}; e.lat = sh + 1; end
      4'h9: begin e.br = (a == b); e.res = {31'b0, e.br}; end
      4'hA: begin e.br = (a != b); e.res = {31'b0, e.br}; end
      4'hB: begin e.br = ($signed(a) <  $signed(b)); e.res = {31'b0, e.br}; end
      4'hC: begin e.br = ($signed(a) >= $signed(b)); e.res = {31'b0, e.br}; end
      4'hD: e.res = b;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s [%s]: observed %h expected %h", tag, cur, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, compare, optionally stall the output.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    exp_t        e;
    int          cyc;
    logic [31:0] held;
    cur = name;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    operation = op;
    src_a     = a;
    src_b     = b;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    src_a     = $urandom;
    src_b     = $urandom;
    operation = 4'($urandom);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
    end
    e = sb.pop_front();
    chk("latency", 32'(cyc), 32'(e.lat));
    chk("result", result, e.res);
    chk("branch_taken", 32'(branch_taken), 32'(e.br));
    chk("illegal_op", 32'(illegal_op), 32'(e.ill));
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_result_stable", result, held);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_branch", 32'(branch_taken), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    logic        saw_valid;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operation = 4'h0;
    src_a     = '0;
    src_b     = '0;
    #12;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    run_op("ADD",  4'h3, 32'h7FFF_FFFF, 32'h1, 0);
    run_op("SUB",  4'h4, 32'h0, 32'h1, 0);
    run_op("SRA31", 4'h6, 32'h8000_0000, 32'd31, 0);
    run_op("SLL0", 4'h7, 32'hDEAD_BEEF, 32'd0, 0);
    run_op("SLA4", 4'h8, 32'h8000_0001, 32'd4, 0);
    run_op("SRL3", 4'h5, 32'hF000_000F, 32'h0000_0023, 0);
    run_op("SLT",  4'hB, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("GE",   4'hC, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("EQ",   4'h9, 32'h1234, 32'h1234, 0);
    run_op("NE",   4'hA, 32'h1234, 32'h1234, 0);
    run_op("ILL_E", 4'hE, 32'hFFFF_FFFF, 32'h5, 0);
    run_op("ILL_F", 4'hF, 32'h1, 32'h2, 0);
    run_op("LUI",  4'hD, 32'h1, 32'hABCD_0000, 0);
    run_op("AND",  4'h0, 32'hF0F0_1234, 32'hFF00_FF00, 0);
    run_op("OR",   4'h1, 32'hF0F0_1234, 32'h0F00_0001, 0);
    run_op("XOR_BP", 4'h2, 32'hA5A5_A5A5, 32'hFFFF_0000, 5);

    // Flush mid-shift: the op must vanish and the unit return to idle.
    cur  = "FLUSH_SHIFT";
    prev = result;
    @(negedge clk);
    in_valid  = 1'b1;
    operation = 4'h5;
    src_a     = 32'hFFFF_FFFF;
    src_b     = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_result_kept", result, prev);
    saw_valid = out_valid;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | out_valid;
    end
    chk("flush_no_out_valid", 32'(saw_valid), 32'd0);

    // Flush together with an accept in IDLE: the op is dropped.
    cur = "FLUSH_ACCEPT";
    @(negedge clk);
    in_valid  = 1'b1;
    flush     = 1'b1;
    operation = 4'h3;
    src_a     = 32'h1;
    src_b     = 32'h1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    chk("flush_drop_out_valid", 32'(out_valid), 32'd0);
    chk("flush_drop_in_ready", 32'(in_ready), 32'd1);
    chk("flush_drop_result", result, prev);

    run_op("ADD_after_flush", 4'h3, 32'h1234_5678, 32'h1111_1111, 0);

    // Asynchronous reset in the middle of a shift.
    cur = "RESET_SHIFT";
    @(negedge clk);
    in_valid  = 1'b1;
    operation = 4'h7;
    src_a     = 32'h1;
    src_b     = 32'd25;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    run_op("EQ_after_reset", 4'h9, 32'h5, 32'h6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
